rr_arbiter8: RTL and testbench

//   8-requester round-robin arbiter for one shared resource. Samples 8 request

---
 rtl/rr_arbiter8.sv | 86 ++++++++
 tb/tb_rr_arbiter8.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - 8-requester round-robin arbiter with hold limit and timeout pulse
module rr_arbiter8 #(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic       grant_valid,
    output logic [2:0] grant_idx,
    output logic [7:0] grant,
    output logic       timeout
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic       HOLD_EN   = (HOLD_MAX != 0);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    state_t     state;
    logic [2:0] ptr;
    logic [7:0] hold_cnt;

    logic [2:0] pick_idx;
    logic       pick_found;
    logic       rel_done;
    logic       rel_drop;
    logic       rel_hold;
    logic       release_now;

    // Scan from the far end so the requester closest to ptr is the one left standing.
    always_comb begin
        pick_idx   = 3'd0;
        pick_found = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (req[ptr + 3'(i)]) begin
                pick_idx   = ptr + 3'(i);
                pick_found = 1'b1;
            end
        end
    end

    assign rel_done    = done;
    assign rel_drop    = !req[grant_idx];
    assign rel_hold    = HOLD_EN && (hold_cnt == HOLD_LAST);
    assign release_now = rel_done || rel_drop || rel_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= 3'd0;
            hold_cnt    <= 8'd0;
            grant_valid <= 1'b0;
            grant_idx   <= 3'd0;
            grant       <= 8'h00;
            timeout     <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state       <= BUSY;
                        grant_valid <= 1'b1;
                        grant_idx   <= pick_idx;
                        grant       <= 8'b1 << pick_idx;
                        hold_cnt    <= 8'd0;
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        state       <= IDLE;
                        grant_valid <= 1'b0;
                        grant_idx   <= 3'd0;
                        grant       <= 8'h00;
                        ptr         <= grant_idx + 3'd1;
                        timeout     <= rel_hold && !rel_done && !rel_drop;
                    end else if (hold_cnt != 8'hFF) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb/tb_rr_arbiter8.sv - self-checking bench for rr_arbiter8 with three HOLD_MAX variants
module tb_rr_arbiter8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       done;

    logic       gv [3];
    logic [2:0] gi [3];
    logic [7:0] gr [3];
    logic       to [3];
    logic [2:0] ptr_obs [3];

    int checks = 0;
    int errors = 0;

    // Reference: who owns the resource, for how many cycles, and the next priority slot.
    int hmax    [3] = '{16, 4, 0};
    int m_owner [3] = '{-1, -1, -1};
    int m_ptr   [3] = '{0, 0, 0};
    int m_held  [3] = '{0, 0, 0};
    bit m_to    [3] = '{0, 0, 0};

    always #5 clk = ~clk;

    rr_arbiter8 #(.HOLD_MAX(16)) u_h16 (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .grant_valid(gv[0]), .grant_idx(gi[0]), .grant(gr[0]), .timeout(to[0])
    );
    rr_arbiter8 #(.HOLD_MAX(4)) u_h4 (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .grant_valid(gv[1]), .grant_idx(gi[1]), .grant(gr[1]), .timeout(to[1])
    );
    rr_arbiter8 #(.HOLD_MAX(0)) u_h0 (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .grant_valid(gv[2]), .grant_idx(gi[2]), .grant(gr[2]), .timeout(to[2])
    );

    assign ptr_obs[0] = u_h16.ptr;
    assign ptr_obs[1] = u_h4.ptr;
    assign ptr_obs[2] = u_h0.ptr;

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_owner[k] = -1;
                m_ptr[k]   = 0;
                m_held[k]  = 0;
                m_to[k]    = 0;
            end else if (m_owner[k] < 0) begin
                m_to[k] = 0;
                for (int j = 0; j < 8; j++) begin
                    if (req[(m_ptr[k] + j) % 8]) begin
                        m_owner[k] = (m_ptr[k] + j) % 8;
                        m_held[k]  = 1;
                        break;
                    end
                end
            end else begin
                bit voluntary;
                bit limit;
                voluntary = done || !req[m_owner[k]];
                limit     = (hmax[k] != 0) && (m_held[k] >= hmax[k]);
                if (voluntary || limit) begin
                    m_to[k]    = limit && !voluntary;
                    m_ptr[k]   = (m_owner[k] + 1) % 8;
                    m_owner[k] = -1;
                end else begin
                    m_held[k] = m_held[k] + 1;
                    m_to[k]   = 0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            bit  own;
            own = (m_owner[k] >= 0);
            chk($sformatf("h%0d.grant_valid t=%0t", hmax[k], $time), 8'(gv[k]), 8'(own));
            chk($sformatf("h%0d.grant_idx t=%0t", hmax[k], $time), 8'(gi[k]),
                own ? 8'(m_owner[k]) : 8'd0);
            chk($sformatf("h%0d.grant t=%0t", hmax[k], $time), gr[k],
                own ? 8'(1 << m_owner[k]) : 8'h00);
            chk($sformatf("h%0d.timeout t=%0t", hmax[k], $time), 8'(to[k]), 8'(m_to[k]));
            chk($sformatf("h%0d.ptr t=%0t", hmax[k], $time), 8'(ptr_obs[k]), 8'(m_ptr[k]));
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = 8'hFF;
        done = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        logic [2:0] seq[$];

        rst  = 1'b1;
        req  = 8'h00;
        done = 1'b0;
        @(negedge clk);

        // Reset with all requests up: nothing granted.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset.grant_valid h%0d", hmax[k]), 8'(gv[k]), 8'd0);
            chk($sformatf("reset.grant h%0d", hmax[k]), gr[k], 8'h00);
        end

        // Two requesters at opposite ends, owner releases with done.
        req = 8'b1000_0001;
        cyc();
        cyc();
        done = 1'b1;
        cyc();
        done = 1'b0;
        cyc();
        chk("two_req.idx7_grant", gr[0], 8'h80);
        cyc();
        done = 1'b1;
        cyc();
        done = 1'b0;
        req  = 8'h00;
        cyc();

        // Every requester asks, done every busy cycle: strict rotation with gaps.
        do_reset();
        req  = 8'hFF;
        done = 1'b1;
        for (int c = 0; c < 18; c++) begin
            cyc();
            if (gv[0]) seq.push_back(gi[0]);
        end
        chk("rotation.count", 8'(seq.size()), 8'd9);
        for (int i = 0; i < seq.size() && i < 9; i++)
            chk($sformatf("rotation.idx%0d", i), 8'(seq[i]), 8'(i % 8));
        done = 1'b0;

        // Single requester held without done: hold limit, timeout, re-grant.
        do_reset();
        req = 8'b0000_1000;
        for (int c = 0; c < 40; c++) cyc();

        // Owner drops request and asserts done together on idx 5.
        do_reset();
        req = 8'h20;
        cyc();
        cyc();
        req  = 8'h00;
        done = 1'b1;
        cyc();
        done = 1'b0;
        chk("drop_done.ptr6", 8'(ptr_obs[0]), 8'd6);
        chk("drop_done.no_timeout", 8'(to[0]), 8'd0);

        // Unlimited hold for 300 cycles on the HOLD_MAX=0 instance.
        req = 8'h01;
        for (int c = 0; c < 300; c++) cyc();
        chk("nolimit.still_valid", 8'(gv[2]), 8'd1);

        // Reset while busy on idx 2, then two requesters.
        do_reset();
        req = 8'b0000_0100;
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        chk("midreset.grant_valid", 8'(gv[0]), 8'd0);
        rst = 1'b0;
        req = 8'b0000_0110;
        cyc();
        chk("midreset.first_idx1", 8'(gi[0]), 8'd1);
        cyc();

        // Randomized traffic against the reference.
        for (int c = 0; c < 2000; c++) begin
            rst = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 3) == 0) req = 8'($urandom);
            done = ($urandom_range(0, 6) == 0);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
